// File: rtl/quidditch_pkg.sv
// Shared pitch constants, coordinate/state types and the wall-bounce step helper.
package quidditch_pkg;

  localparam int unsigned DEF_FIELD_LEFT   = 144;
  localparam int unsigned DEF_FIELD_RIGHT  = 660;
  localparam int unsigned DEF_FIELD_TOP    = 35;
  localparam int unsigned DEF_FIELD_BOTTOM = 515;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    ROAM    = 2'd0,
    HIT     = 2'd1,
    RESPAWN = 2'd2
  } bludger_state_t;

  // One axis of ball motion: up=1 means the coordinate is increasing.
  typedef struct packed {
    logic   up;
    coord_t pos;
  } axis_t;

  // Reflect at the wall in the same step that reaches it, otherwise keep moving.
  function automatic axis_t axis_step(axis_t cur, coord_t lo, coord_t hi);
    axis_t nxt;
    nxt = cur;
    if (cur.up && cur.pos == hi) begin
      nxt.up  = 1'b0;
      nxt.pos = cur.pos - coord_t'(1);
    end else if (!cur.up && cur.pos == lo) begin
      nxt.up  = 1'b1;
      nxt.pos = cur.pos + coord_t'(1);
    end else if (cur.up) begin
      nxt.pos = cur.pos + coord_t'(1);
    end else begin
      nxt.pos = cur.pos - coord_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bludger_controller_if.sv
// Bludger <-> player controller link: ball position, hit handshake and hit counter.
interface bludger_controller_if;
  import quidditch_pkg::*;

  coord_t     player_hor_pos;
  logic       clean_bludge;
  coord_t     ball_x;
  coord_t     ball_y;
  logic       bludged;
  logic [3:0] hit_count;

  modport master (
    input  player_hor_pos, clean_bludge,
    output ball_x, ball_y, bludged, hit_count
  );

  modport slave (
    output player_hor_pos, clean_bludge,
    input  ball_x, ball_y, bludged, hit_count
  );
endinterface

// File: rtl/circle_overlap.sv
// Registered strict-overlap test of two circles given their centres and radius sum.
module circle_overlap
  import quidditch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  coord_t     a_x,
  input  coord_t     a_y,
  input  coord_t     b_x,
  input  coord_t     b_y,
  input  logic [7:0] radius_sum,
  output logic       overlap
);

  logic signed [10:0] ddx, ddy;
  logic [9:0]         mag_x, mag_y;
  logic [20:0]        sq_x, sq_y;
  logic [21:0]        dist_sq, limit_sq;

  always_comb begin
    ddx      = $signed({1'b0, a_x}) - $signed({1'b0, b_x});
    ddy      = $signed({1'b0, a_y}) - $signed({1'b0, b_y});
    mag_x    = ddx[10] ? 10'(-ddx) : ddx[9:0];
    mag_y    = ddy[10] ? 10'(-ddy) : ddy[9:0];
    sq_x     = 21'(mag_x) * 21'(mag_x);
    sq_y     = 21'(mag_y) * 21'(mag_y);
    dist_sq  = 22'(sq_x) + 22'(sq_y);
    limit_sq = 22'(radius_sum) * 22'(radius_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overlap <= 1'b0;
    end else begin
      overlap <= (dist_sq < limit_sq);
    end
  end

endmodule

// File: rtl/bludger_controller.sv
// Bludger top: roaming/bouncing motion, hit detection on the tracked player, freeze and respawn.
module bludger_controller
  import quidditch_pkg::*;
#(
  parameter int unsigned BALL_RADIUS        = 12,
  parameter int unsigned PLAYER_RADIUS      = 25,
  parameter int unsigned PLAYER_VER_POS     = 450,
  parameter int unsigned INITIAL_X          = 400,
  parameter int unsigned INITIAL_Y          = 100,
  parameter int unsigned MOVEMENT_FREQUENCY = 200000,
  parameter int unsigned FIELD_LEFT         = DEF_FIELD_LEFT,
  parameter int unsigned FIELD_RIGHT        = DEF_FIELD_RIGHT,
  parameter int unsigned FIELD_TOP          = DEF_FIELD_TOP,
  parameter int unsigned FIELD_BOTTOM       = DEF_FIELD_BOTTOM
) (
  input logic                  clk,
  input logic                  rst_n,
  bludger_controller_if.master bus
);

  localparam int unsigned CntW   = $clog2(MOVEMENT_FREQUENCY);
  localparam logic [CntW-1:0] CntMax = CntW'(MOVEMENT_FREQUENCY - 1);
  localparam coord_t XMin  = coord_t'(FIELD_LEFT + BALL_RADIUS);
  localparam coord_t XMax  = coord_t'(FIELD_RIGHT - BALL_RADIUS);
  localparam coord_t YMin  = coord_t'(FIELD_TOP + BALL_RADIUS);
  localparam coord_t YMax  = coord_t'(FIELD_BOTTOM - BALL_RADIUS);
  localparam coord_t InitX = coord_t'(INITIAL_X);
  localparam coord_t InitY = coord_t'(INITIAL_Y);
  localparam coord_t PlayerY = coord_t'(PLAYER_VER_POS);
  localparam logic [7:0] RadiusSum = 8'(PLAYER_RADIUS + BALL_RADIUS);

  bludger_state_t  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  axis_t           ax_q, ax_d, ay_q, ay_d;
  logic [3:0]      hc_q, hc_d;
  logic            fresh_q, fresh_d;
  logic            hit_q;

  circle_overlap u_overlap (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_x        (ax_q.pos),
    .a_y        (ay_q.pos),
    .b_x        (bus.player_hor_pos),
    .b_y        (PlayerY),
    .radius_sum (RadiusSum),
    .overlap    (hit_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    hc_d    = hc_q;
    fresh_d = (state_q == RESPAWN);
    unique case (state_q)
      ROAM: begin
        if (cnt_q == CntMax) begin
          cnt_d = '0;
          ax_d  = axis_step(ax_q, XMin, XMax);
          ay_d  = axis_step(ay_q, YMin, YMax);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // hit_q in the first ROAM cycle still reflects the pre-respawn position.
        if (hit_q && !fresh_q) begin
          state_d = HIT;
          if (hc_q != 4'hf) hc_d = hc_q + 4'd1;
        end
      end
      HIT: begin
        if (bus.clean_bludge) state_d = RESPAWN;
      end
      RESPAWN: begin
        ax_d.pos = InitX;
        ax_d.up  = ~ax_q.up;
        ay_d.pos = InitY;
        cnt_d    = '0;
        state_d  = ROAM;
      end
      default: state_d = ROAM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ROAM;
      cnt_q   <= '0;
      ax_q    <= '{up: 1'b1, pos: InitX};
      ay_q    <= '{up: 1'b1, pos: InitY};
      hc_q    <= 4'd0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      hc_q    <= hc_d;
      fresh_q <= fresh_d;
    end
  end

  assign bus.ball_x    = ax_q.pos;
  assign bus.ball_y    = ay_q.pos;
  assign bus.bludged   = (state_q == HIT);
  assign bus.hit_count = hc_q;

endmodule

// File: tb/tb_bludger_controller.sv
// Directed bench with an expected-value queue for bludger_controller (MOVEMENT_FREQUENCY=4).
module tb_bludger_controller;
  import quidditch_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   track;
  coord_t player_pos;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       b;
    logic [3:0] hc;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];

  bludger_controller_if bus_m ();
  bludger_controller_if bus_c ();

  // Tracking mode keeps ddx at zero so only the vertical distance matters.
  assign bus_m.player_hor_pos = track ? bus_m.ball_x : player_pos;
  assign bus_c.player_hor_pos = 10'd150;
  assign bus_c.clean_bludge   = 1'b0;

  bludger_controller #(.MOVEMENT_FREQUENCY(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m)
  );

  bludger_controller #(.MOVEMENT_FREQUENCY(4), .INITIAL_X(646), .INITIAL_Y(501)) u_corner (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_c)
  );

  always #5 clk = ~clk;

  function automatic obs_t obs_main();
    return {bus_m.ball_x, bus_m.ball_y, bus_m.bludged, bus_m.hit_count};
  endfunction

  function automatic obs_t obs_corner();
    return {bus_c.ball_x, bus_c.ball_y, bus_c.bludged, bus_c.hit_count};
  endfunction

  task automatic push(input string tag, input int x, input int y, input bit b, input int hc);
    obs_t e;
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.b  = b;
    e.hc = 4'(hc);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check(input obs_t got);
    obs_t  e;
    string t;
    n_assert++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed x=%0d y=%0d, no expected entry", got.x, got.y);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_assert++;
      assert (got === e) else begin
        n_fail++;
        $error("FAIL %s: observed x=%0d y=%0d bludged=%0b hits=%0d, expected x=%0d y=%0d bludged=%0b hits=%0d",
               t, got.x, got.y, got.b, got.hc, e.x, e.y, e.b, e.hc);
      end
    end
  endtask

  task automatic check_found(input string tag, input bit found);
    n_assert++;
    assert (found === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed timeout, expected event within budget", tag);
    end
  endtask

  // mode 0: wait for ball_y==413, mode 1: wait for bludged==1; sampled on negedges.
  task automatic wait_main(input int mode, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (mode == 0) found = (bus_m.ball_y == 10'd413);
      else           found = (bus_m.bludged == 1'b1);
    end
  endtask

  initial begin
    bit found;
    int hc;
    rst_n              = 1'b0;
    track              = 1'b0;
    player_pos         = 10'd200;
    bus_m.clean_bludge = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    push("reset", 400, 100, 0, 0);         check(obs_main());
    push("corner_reset", 646, 501, 0, 0);  check(obs_corner());
    repeat (4) @(negedge clk);
    push("step1", 401, 101, 0, 0);         check(obs_main());
    push("corner_step1", 647, 502, 0, 0);  check(obs_corner());
    repeat (4) @(negedge clk);
    push("step2", 402, 102, 0, 0);         check(obs_main());
    push("corner_at_wall", 648, 503, 0, 0); check(obs_corner());
    repeat (4) @(negedge clk);
    push("corner_bounce", 647, 502, 0, 0); check(obs_corner());
    repeat (4) @(negedge clk);
    push("corner_after", 646, 501, 0, 0);  check(obs_corner());

    // Ball y=413 sits exactly at distance 37 from the player: no overlap.
    track = 1'b1;
    wait_main(0, 2000, found);
    check_found("reach_y413", found);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push("boundary_37", 583, 413, 0, 0); check(obs_main());
    end
    @(negedge clk);
    push("overlap_cycle", 582, 414, 0, 0); check(obs_main());
    @(negedge clk);
    push("hit_q_cycle", 582, 414, 0, 0);   check(obs_main());
    @(negedge clk);
    push("bludged", 582, 414, 1, 1);       check(obs_main());
    repeat (100) @(negedge clk);
    push("frozen", 582, 414, 1, 1);        check(obs_main());

    bus_m.clean_bludge = 1'b1;
    @(negedge clk);
    bus_m.clean_bludge = 1'b0;
    push("release", 582, 414, 0, 1);       check(obs_main());
    @(negedge clk);
    push("respawn", 400, 100, 0, 1);       check(obs_main());
    repeat (3) @(negedge clk);
    push("respawn_hold", 400, 100, 0, 1);  check(obs_main());
    @(negedge clk);
    push("respawn_dx", 401, 101, 0, 1);    check(obs_main());

    for (int i = 2; i <= 16; i++) begin
      hc = (i > 15) ? 15 : i;
      wait_main(1, 2000, found);
      check_found("wait_hit", found);
      push("hit_n", 582, 414, 1, hc);      check(obs_main());
      bus_m.clean_bludge = 1'b1;
      @(negedge clk);
      if (i == 2) begin
        @(negedge clk);
        bus_m.clean_bludge = 1'b0;
        push("release_held", 400, 100, 0, hc); check(obs_main());
        @(negedge clk);
        push("no_second_respawn", 400, 100, 0, hc); check(obs_main());
      end else begin
        bus_m.clean_bludge = 1'b0;
        @(negedge clk);
      end
    end

    wait_main(1, 2000, found);
    check_found("wait_hit17", found);
    push("saturate", 582, 414, 1, 15);     check(obs_main());

    rst_n = 1'b0;
    #1;
    push("reset_mid_hit", 400, 100, 0, 0); check(obs_main());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bludger_controller.md
# bludger_controller

Drives the bludger: a ball that roams the pitch autonomously, bouncing off the field walls. It detects contact with one horizontal player and raises `bludged` to that player's controller. It holds the player frozen until the controller returns `clean_bludge`, then respawns the ball. It sits beside the player controller and is the driving end of its `bludged`/`clean_bludge` handshake; `ball_y` also feeds that controller's blocking-ball Y input.

## Interface
- `BALL_RADIUS`, 12, bludger radius in px
- `PLAYER_RADIUS`, 25, player radius in px; must match the player controller
- `PLAYER_VER_POS`, 450, fixed vertical position of the tracked player
- `INITIAL_X`, 400, X coordinate at reset and respawn
- `INITIAL_Y`, 100, Y coordinate at reset and respawn
- `MOVEMENT_FREQUENCY`, 200000, clocks per one-pixel step; must be ≥ 2
- `FIELD_LEFT`, 144 / `FIELD_RIGHT`, 660 / `FIELD_TOP`, 35 / `FIELD_BOTTOM`, 515, pitch bounds in px
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `player_hor_pos`  in  10  player X centre, from the player controller
- `clean_bludge`  in  1  player controller reports that its bludge timeout has expired
- `ball_x`  out  10  bludger X centre
- `ball_y`  out  10  bludger Y centre
- `bludged`  out  1  player is hit and frozen
- `hit_count`  out  4  number of hits, saturating at 15

## Operation
- **Reset values** (asynchronous on `rst_n`=0): `ball_x`=`INITIAL_X`, `ball_y`=`INITIAL_Y`, `bludged`=0, `hit_count`=0, dx=+1, dy=+1, step counter=0, state ROAM.
- **States.**
  - ROAM: ball moves. Go to HIT on a registered collision.
  - HIT: ball frozen, `bludged`=1. Go to RESPAWN when `clean_bludge`=1.
  - RESPAWN: lasts exactly 1 cycle. Loads `INITIAL_X`/`INITIAL_Y`, inverts dx, keeps dy, clears the step counter, then goes to ROAM.
- **Step counter.** Counts 0..`MOVEMENT_FREQUENCY`-1 and wraps to 0. It runs only in ROAM. A step occurs in the cycle where the count equals `MOVEMENT_FREQUENCY`-1.
- **Stepping, X axis.**
  - If dx=+1 and `ball_x`=`FIELD_RIGHT`-`BALL_RADIUS`: set dx=-1 and `ball_x`-=1.
  - If dx=-1 and `ball_x`=`FIELD_LEFT`+`BALL_RADIUS`: set dx=+1 and `ball_x`+=1.
  - Otherwise `ball_x`+=dx.
- **Stepping, Y axis.** Same rule with `FIELD_TOP`/`FIELD_BOTTOM`. The axes are independent, so a corner flips both directions on the same step.
- **Collision arithmetic.**
  - ddx = `ball_x`-`player_hor_pos` and ddy = `ball_y`-`PLAYER_VER_POS`, each 11-bit signed.
  - Squares are 21-bit unsigned; their sum is 22-bit.
  - Overlap is true when the sum is strictly less than (`PLAYER_RADIUS`+`BALL_RADIUS`)².
- **Hit capture.** Overlap is evaluated every cycle and registered into `hit_q`. `hit_q`=1 while in ROAM causes the transition to HIT. `hit_count` increments once on that transition and saturates at 15.
- **Masking.** `hit_q` is ignored in HIT and RESPAWN.
- **`clean_bludge` outside HIT.** Ignored in ROAM and RESPAWN. The player controller holds `clean_bludge` high one cycle after `bludged` falls; this must not trigger a second respawn.
- **Bludge timeout.** No internal timeout; HIT is held indefinitely until `clean_bludge` arrives.

## Timing
- **Step latency.** A step updates `ball_x`/`ball_y` at the edge that ends the terminal-count cycle.
- **Hit latency.**
  - Overlap in cycle n → `hit_q`=1 at edge n+1 → `bludged`=1 at edge n+2.
  - A step falling in cycle n+1 is still applied; freezing starts in HIT.
- **Release latency.**
  - `clean_bludge`=1 sampled in HIT at edge m → `bludged`=0 and state RESPAWN from edge m.
  - New position visible after edge m+1; ROAM starts from edge m+1.
- **Mid-operation reset.** `rst_n` low in any state returns to the reset values immediately; no handshake completion is required.

## Structure
- **Shared package `quidditch_pkg`.**
  - Field-bound constants (144/660/35/515).
  - State enum `bludger_state_t` {ROAM, HIT, RESPAWN}.
  - 10-bit coordinate typedef `coord_t`.
- **Sub-module `circle_overlap`.**
  - Inputs: two centres and a radius sum. Output: the registered overlap flag, carrying its own `clk`/`rst_n`.
  - Reusable later for the player controller's blocking check.
- The top level holds the FSM, step counter and direction bits.

## Test plan
Bench uses `MOVEMENT_FREQUENCY`=4.
- **Reset and step.** Release reset, player at 200 → ball (400,100); after 4 clks (401,101); after 8 clks (402,102); `bludged`=0.
- **Right-wall bounce.** Force the ball to X=648 with dx=+1 → next step gives X=647 and dx=-1. At a corner (648,503), both directions flip → (647,502).
- **Hit.** Player at 400, ball driven to (400,414) → distance 36 < 37 → `bludged`=1 two cycles after overlap, `hit_count`=1, position frozen for 100 clks.
- **Release.**
  - Pulse `clean_bludge` in HIT → `bludged`=0 next edge; ball at (400,100) one edge later, dx inverted.
  - Holding `clean_bludge` high 1 extra cycle causes no further effect.
- **Boundary overlap.** Distance exactly 37 (ddy=37, ddx=0) → no hit. Sixteen hits → `hit_count` stays at 15.
- **Reset mid-HIT.** Assert `rst_n`=0 during HIT → immediately `bludged`=0, ball (400,100), `hit_count`=0.
